// File: rtl/iir_feed_ctrl_pkg.sv
// Shared state encoding for the IIR feed sequencer and its surroundings.
package iir_feed_ctrl_pkg;

    localparam int NB_STATE = 2;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/iir_feed_ctrl_slot_strobe.sv
// Loadable down-counter that holds at zero; zero marks an open rate slot.
// A consume pulse closes the slot by reloading the period.
module slot_strobe #(
    parameter int NB_DIV = 8
) (
    input  logic              clock,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [NB_DIV-1:0] i_load_val,
    input  logic              i_consume,
    input  logic [NB_DIV-1:0] i_reload_val,
    output logic              o_slot
);

    logic [NB_DIV-1:0] cnt_q;
    logic [NB_DIV-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_consume) begin
            cnt_d = i_reload_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_slot = (cnt_q == '0);

endmodule

// File: rtl/iir_feed_ctrl.sv
// Sequencer for the 8-bit IIR core: clear, run at a programmable sample rate,
// then drain the filter tail with zeros and return tagged results.
module iir_feed_ctrl
    import iir_feed_ctrl_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_DIV    = 8,
    parameter int CLR_CYC   = 2,
    parameter int DRAIN_LEN = 4,
    parameter int FILT_LAT  = 1
) (
    input  logic                clock,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_DIV-1:0]   i_div,
    input  logic [NB_DATA-1:0]  i_x,
    input  logic                i_x_valid,
    output logic                o_x_ready,
    output logic [NB_DATA-1:0]  o_filt_x,
    output logic                o_filt_en,
    output logic                o_filt_rst_n,
    input  logic [NB_DATA-1:0]  i_filt_y,
    output logic [NB_DATA-1:0]  o_y,
    output logic                o_y_valid,
    output logic                o_busy,
    output logic [NB_STATE-1:0] o_state
);

    // Handshake: a sample moves when i_x_valid and o_x_ready are both high in
    // the same cycle; ready only rises in RUN while a rate slot is open.

    localparam int NB_CLR = $clog2(CLR_CYC + 1);
    localparam int NB_DRN = $clog2(DRAIN_LEN + 1);
    localparam logic [NB_CLR-1:0] CLR_LAST = NB_CLR'(CLR_CYC - 1);
    localparam logic [NB_DRN-1:0] DRN_LAST = NB_DRN'(DRAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [NB_DIV-1:0]    div_q, div_d;
    logic [NB_CLR-1:0]    clr_cnt_q, clr_cnt_d;
    logic [NB_DRN-1:0]    drn_cnt_q, drn_cnt_d;
    logic [NB_DATA-1:0]   filt_x_q, filt_x_d;
    logic                 filt_en_q, filt_en_d;
    logic [FILT_LAT-1:0]  vld_q, vld_d;
    logic [NB_DATA-1:0]   y_q, y_d;
    logic                 y_valid_q, y_valid_d;

    logic slot;
    logic accept;
    logic drain_feed;
    logic start_run;
    logic slot_reload;

    // Open the first slot immediately on entering RUN; reload the period on
    // every feed, and on stop so a dropped pending slot is not reused by DRAIN.
    slot_strobe #(
        .NB_DIV (NB_DIV)
    ) u_slot (
        .clock        (clock),
        .i_rst        (i_rst),
        .i_load       (start_run),
        .i_load_val   ('0),
        .i_consume    (slot_reload),
        .i_reload_val (div_q),
        .o_slot       (slot)
    );

    // State register
    always_ff @(posedge clock) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_feed && (drn_cnt_q == DRN_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        start_run    = (state_q == ST_IDLE) && i_start;
        accept       = (state_q == ST_RUN) && slot && i_x_valid;
        drain_feed   = (state_q == ST_DRAIN) && slot;
        slot_reload  = accept || drain_feed || ((state_q == ST_RUN) && i_stop);
        o_x_ready    = accept;
        o_busy       = (state_q != ST_IDLE);
        o_state      = state_q;
        o_filt_rst_n = ~(i_rst | (state_q == ST_CLEAR));
    end

    always_comb begin
        div_d     = start_run ? i_div : div_q;
        clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
        drn_cnt_d = '0;
        if (state_q == ST_DRAIN) begin
            drn_cnt_d = drain_feed ? drn_cnt_q + 1'b1 : drn_cnt_q;
        end

        filt_en_d = accept || drain_feed;
        filt_x_d  = filt_x_q;
        if (accept) begin
            filt_x_d = i_x;
        end else if (drain_feed) begin
            filt_x_d = '0;
        end

        // The oldest pipe stage marks the cycle the core result is valid.
        vld_d[0] = filt_en_q;
        for (int i = 1; i < FILT_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        y_valid_d = vld_q[FILT_LAT-1];
        y_d       = vld_q[FILT_LAT-1] ? i_filt_y : y_q;
    end

    always_ff @(posedge clock) begin
        if (i_rst) begin
            div_q     <= '0;
            clr_cnt_q <= '0;
            drn_cnt_q <= '0;
            filt_x_q  <= '0;
            filt_en_q <= 1'b0;
            vld_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            clr_cnt_q <= clr_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            filt_x_q  <= filt_x_d;
            filt_en_q <= filt_en_d;
            vld_q     <= vld_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign o_filt_x  = filt_x_q;
    assign o_filt_en = filt_en_q;
    assign o_y       = y_q;
    assign o_y_valid = y_valid_q;

endmodule

// File: tb/tb_iir_feed_ctrl.sv
// Directed bench for iir_feed_ctrl with a behavioural model of the ej_4 IIR core attached.
module tb_iir_feed_ctrl;

    logic       clock;
    logic       i_rst;
    logic       i_start;
    logic       i_stop;
    logic [7:0] i_div;
    logic [7:0] i_x;
    logic       i_x_valid;
    logic       o_x_ready;
    logic [7:0] o_filt_x;
    logic       o_filt_en;
    logic       o_filt_rst_n;
    logic [7:0] i_filt_y;
    logic [7:0] o_y;
    logic       o_y_valid;
    logic       o_busy;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int zero_cnt = 0;
    int yv_cnt = 0;
    logic sb_on = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_e;

    iir_feed_ctrl dut (
        .clock        (clock),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_div        (i_div),
        .i_x          (i_x),
        .i_x_valid    (i_x_valid),
        .o_x_ready    (o_x_ready),
        .o_filt_x     (o_filt_x),
        .o_filt_en    (o_filt_en),
        .o_filt_rst_n (o_filt_rst_n),
        .i_filt_y     (i_filt_y),
        .o_y          (o_y),
        .o_y_valid    (o_y_valid),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Core model: y[n]=x[n]-x[n-1]+x[n-2]+x[n-3]+y[n-1]/2+y[n-2]/4, one cycle latency
    logic [7:0] cx1, cx2, cx3, cy1, cy2;
    assign i_filt_y = cy1;

    function automatic logic [7:0] core_next(input logic [7:0] x);
        return x - cx1 + cx2 + cx3 + (cy1 >> 1) + (cy2 >> 2);
    endfunction

    always @(posedge clock) begin
        if (!o_filt_rst_n) begin
            cx1 <= '0; cx2 <= '0; cx3 <= '0; cy1 <= '0; cy2 <= '0;
        end else if (o_filt_en) begin
            cy1 <= core_next(o_filt_x);
            cy2 <= cy1;
            cx3 <= cx2;
            cx2 <= cx1;
            cx1 <= o_filt_x;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard and event counters
    always @(negedge clock) begin
        if (o_filt_en) begin
            en_cnt++;
            if (o_filt_x == 8'd0) zero_cnt++;
        end
        if (o_y_valid) begin
            yv_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", 32'(o_y), 32'hFFFF_FFFF);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_y", 32'(o_y), 32'(sb_e));
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_x = '0; i_x_valid = 1'b0; i_div = '0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (o_state == st) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_state", 32'(o_state), 32'(st));
    endtask

    task automatic start_run(input logic [7:0] div);
        tick();
        i_div = div;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_state(2'd2, 10);
    endtask

    task automatic feed(input logic [7:0] x, input logic stop);
        tick();
        i_x = x;
        i_x_valid = 1'b1;
        i_stop = stop;
        @(negedge clock);
        chk("x_ready", 32'(o_x_ready), 32'd1);
    endtask

    task automatic stop_pulse();
        tick();
        i_x_valid = 1'b0;
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    int en0, yv0, zr0, rdy, bad, last_en;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_div = '0; i_x = '0; i_x_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_filt_en", 32'(o_filt_en), 32'd0);
        chk("rst_filt_x", 32'(o_filt_x), 32'd0);
        chk("rst_y", 32'(o_y), 32'd0);
        chk("rst_y_valid", 32'(o_y_valid), 32'd0);
        chk("rst_core_rst_n", 32'(o_filt_rst_n), 32'd0);
        tick();
        i_rst = 1'b0;

        // Back-to-back samples at full rate, then a separate stop and drain
        do_reset();
        sb_on = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        push_exp(8'd1); push_exp(8'd1); push_exp(8'd2); push_exp(8'd5);
        push_exp(8'd4); push_exp(8'd11); push_exp(8'd9); push_exp(8'd9);
        push_exp(8'd8); push_exp(8'd6);
        en0 = en_cnt; yv0 = yv_cnt; zr0 = zero_cnt;
        start_run(8'd0);
        chk("run_core_rst_n", 32'(o_filt_rst_n), 32'd1);
        feed(8'd1, 1'b0); feed(8'd2, 1'b0); feed(8'd3, 1'b0);
        feed(8'd4, 1'b0); feed(8'd1, 1'b0); feed(8'd2, 1'b0);
        stop_pulse();
        wait_state(2'd0, 20);
        repeat (4) @(negedge clock);
        tick();
        chk("t1_sb_left", 32'(exp_q.size()), 32'd0);
        chk("t1_valid_cnt", 32'(yv_cnt - yv0), 32'd10);
        chk("t1_en_cnt", 32'(en_cnt - en0), 32'd10);
        chk("t1_zero_feeds", 32'(zero_cnt - zr0), 32'd4);

        // Divider of 3 with the source always valid
        do_reset();
        sb_on = 1'b0;
        i_x = 8'd5;
        i_x_valid = 1'b1;
        rdy = 0; bad = 0; last_en = -1;
        start_run(8'd3);
        for (int c = 0; c < 16; c++) begin
            if (o_x_ready) begin
                rdy++;
                if ((c % 4) != 0) bad++;
            end
            if (o_filt_en) begin
                if (last_en >= 0) chk("t2_en_gap", 32'(c - last_en), 32'd4);
                last_en = c;
            end
            if (c < 15) @(negedge clock);
        end
        chk("t2_ready_cnt", 32'(rdy), 32'd4);
        chk("t2_ready_phase", 32'(bad), 32'd0);
        stop_pulse();
        wait_state(2'd0, 40);

        // Source gap of three cycles; no stop-time accept, so drain follows directly
        do_reset();
        sb_on = 1'b1;
        push_exp(8'd1); push_exp(8'd1); push_exp(8'd2); push_exp(8'd5);
        push_exp(8'd3); push_exp(8'd9); push_exp(8'd8); push_exp(8'd6);
        start_run(8'd0);
        feed(8'd1, 1'b0); feed(8'd2, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            i_x_valid = 1'b0;
            @(negedge clock);
            if (g == 0) chk("t3_en_last", 32'(o_filt_en), 32'd1);
            else chk("t3_gap_en", 32'(o_filt_en), 32'd0);
        end
        feed(8'd3, 1'b0);
        chk("t3_gap_en_end", 32'(o_filt_en), 32'd0);
        feed(8'd4, 1'b0);
        tick();
        i_x_valid = 1'b0;
        @(negedge clock);
        chk("t3_en_after", 32'(o_filt_en), 32'd1);
        stop_pulse();
        wait_state(2'd0, 20);
        repeat (4) @(negedge clock);
        tick();
        chk("t3_sb_left", 32'(exp_q.size()), 32'd0);

        // Stop coinciding with the fourth accept: sample fed first, then four zeros
        do_reset();
        sb_on = 1'b1;
        push_exp(8'd1); push_exp(8'd1); push_exp(8'd2); push_exp(8'd5);
        push_exp(8'd3); push_exp(8'd9); push_exp(8'd8); push_exp(8'd6);
        en0 = en_cnt; yv0 = yv_cnt; zr0 = zero_cnt;
        start_run(8'd0);
        feed(8'd1, 1'b0); feed(8'd2, 1'b0); feed(8'd3, 1'b0); feed(8'd4, 1'b1);
        tick();
        i_x_valid = 1'b0;
        i_stop = 1'b0;
        @(negedge clock);
        chk("t4_drain_state", 32'(o_state), 32'd3);
        chk("t4_drain_ready", 32'(o_x_ready), 32'd0);
        wait_state(2'd0, 20);
        chk("t4_idle_busy", 32'(o_busy), 32'd0);
        repeat (4) @(negedge clock);
        tick();
        chk("t4_sb_left", 32'(exp_q.size()), 32'd0);
        chk("t4_valid_cnt", 32'(yv_cnt - yv0), 32'd8);
        chk("t4_en_cnt", 32'(en_cnt - en0), 32'd8);
        chk("t4_zero_feeds", 32'(zero_cnt - zr0), 32'd4);

        // Reset in RUN with an enable in flight
        do_reset();
        sb_on = 1'b0;
        start_run(8'd0);
        feed(8'd1, 1'b0); feed(8'd2, 1'b0);
        tick();
        i_x_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge clock);
        chk("t5_core_rst_n", 32'(o_filt_rst_n), 32'd0);
        tick();
        i_rst = 1'b0;
        yv0 = yv_cnt; en0 = en_cnt;
        @(negedge clock);
        chk("t5_state", 32'(o_state), 32'd0);
        chk("t5_y_valid", 32'(o_y_valid), 32'd0);
        repeat (6) @(negedge clock);
        tick();
        chk("t5_late_valid", 32'(yv_cnt - yv0), 32'd0);
        chk("t5_late_en", 32'(en_cnt - en0), 32'd0);

        // Stop during CLEAR, stop ignored in IDLE, start ignored in RUN
        do_reset();
        en0 = en_cnt;
        i_stop = 1'b1;
        @(negedge clock);
        chk("t6_idle_stop", 32'(o_state), 32'd0);
        tick();
        i_stop = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b1;
        @(negedge clock);
        chk("t6_clear_state", 32'(o_state), 32'd1);
        chk("t6_clear_rst_n", 32'(o_filt_rst_n), 32'd0);
        tick();
        i_stop = 1'b0;
        @(negedge clock);
        chk("t6_abort_state", 32'(o_state), 32'd0);
        repeat (5) @(negedge clock);
        tick();
        chk("t6_abort_en", 32'(en_cnt - en0), 32'd0);
        start_run(8'd0);
        tick();
        i_start = 1'b1;
        @(negedge clock);
        chk("t6_run_busy", 32'(o_busy), 32'd1);
        tick();
        i_start = 1'b0;
        @(negedge clock);
        chk("t6_run_start_ign", 32'(o_state), 32'd2);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
